// File: rtl/bus_xfer_pkg.sv
// -----------------------------------------------------------------------------
// bus_xfer_pkg
// Shared definitions for the bus transfer controller:
//   - transfer op encodings (OP_MOVE, OP_SWAP, OP_LOAD, OP_RSVD)
//   - controller state enum
//   - default register count and bus width
//   - command validation helper
// Optional feature macro: BUS_XFER_CTRL_SWAP_EN (enables the SWAP command).
// -----------------------------------------------------------------------------
package bus_xfer_pkg;

    localparam int NREG_DEFAULT = 4;
    localparam int DW_DEFAULT   = 4;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

`ifdef BUS_XFER_CTRL_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP1 = 3'd1,
        S_STEP2 = 3'd2,
        S_STEP3 = 3'd3,
        S_FIN   = 3'd4
    } xfer_state_e;

    // A register-to-register transfer onto itself is meaningless and is
    // rejected; SWAP is only legal when the feature is compiled in.
    function automatic logic cmd_is_valid(input logic [1:0] op, input logic same_idx);
        logic ok;
        case (op)
            OP_MOVE: ok = !same_idx;
            OP_SWAP: ok = SWAP_EN && !same_idx;
            OP_LOAD: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl_if
// Command and enable bundle between a command issuer (master) and the
// bus_xfer_ctrl controller (slave).
//   master -> slave : start, op, src, dst, imm
//   slave -> master : reg_out, reg_in, tmp_out, tmp_in, ext_out, ext_data,
//                     busy, done, err
// -----------------------------------------------------------------------------
interface bus_xfer_ctrl_if #(
    parameter int NREG = 4,
    parameter int DW   = 4
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic            start;
    logic [1:0]      op;
    logic [IW-1:0]   src;
    logic [IW-1:0]   dst;
    logic [DW-1:0]   imm;

    logic [NREG-1:0] reg_out;
    logic [NREG-1:0] reg_in;
    logic            tmp_out;
    logic            tmp_in;
    logic            ext_out;
    logic [DW-1:0]   ext_data;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, op, src, dst, imm,
        input  reg_out, reg_in, tmp_out, tmp_in, ext_out, ext_data, busy, done, err
    );

    modport slave (
        input  start, op, src, dst, imm,
        output reg_out, reg_in, tmp_out, tmp_in, ext_out, ext_data, busy, done, err
    );
endinterface

// File: rtl/bus_xfer_dec.sv
// -----------------------------------------------------------------------------
// bus_xfer_dec
// Register index to one-hot enable decoder with a global enable.
//   i_idx    : register index
//   i_en     : when low, all outputs are 0
//   o_onehot : NREG-bit one-hot select
// -----------------------------------------------------------------------------
module bus_xfer_dec #(
    parameter int NREG = 4,
    parameter int IW   = 2
) (
    input  logic [IW-1:0]   i_idx,
    input  logic            i_en,
    output logic [NREG-1:0] o_onehot
);

    // Compare against every index rather than shifting, so a non power-of-two
    // NREG never selects a bit that does not exist.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            o_onehot[i] = i_en && (i_idx == IW'(i));
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl
// Sequences register-file bus enables for MOVE, LOAD-immediate and (optional)
// SWAP transfers so that exactly one source drives the shared bus per step.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bus_xfer_ctrl_if.slave (command in; enables, busy/done/err out)
// All outputs are registered; the enables for a step are visible for the whole
// cycle that ends on the edge where the datapath latches.
// Optional feature macro: BUS_XFER_CTRL_SWAP_EN (SWAP, STEP2/STEP3, temp
// register enables). Without it op=01 is rejected like a reserved op.
// -----------------------------------------------------------------------------
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    bus_xfer_ctrl_if.slave bus
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_STEP1 = S_STEP1;
`ifdef BUS_XFER_CTRL_SWAP_EN
    localparam logic [2:0] ST_STEP2 = S_STEP2;
    localparam logic [2:0] ST_STEP3 = S_STEP3;
`endif
    localparam logic [2:0] ST_FIN   = S_FIN;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [1:0]      r_op;
    logic [1:0]      w_op_nxt;
    logic [IW-1:0]   r_src;
    logic [IW-1:0]   w_src_nxt;
    logic [IW-1:0]   r_dst;
    logic [IW-1:0]   w_dst_nxt;
    logic [DW-1:0]   r_imm;
    logic [DW-1:0]   w_imm_nxt;

    logic            w_accept;
    logic            w_err_nxt;

    logic            w_out_en;
    logic [IW-1:0]   w_out_idx;
    logic            w_in_en;
    logic [IW-1:0]   w_in_idx;
    logic [NREG-1:0] w_reg_out_nxt;
    logic [NREG-1:0] w_reg_in_nxt;
    logic            w_tmp_out_nxt;
    logic            w_tmp_in_nxt;
    logic            w_ext_out_nxt;
    logic [DW-1:0]   w_ext_data_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    logic [NREG-1:0] r_reg_out;
    logic [NREG-1:0] r_reg_in;
    logic            r_tmp_out;
    logic            r_tmp_in;
    logic            r_ext_out;
    logic [DW-1:0]   r_ext_data;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    // busy is low in IDLE and FIN, so a command may be accepted in the FIN
    // cycle (back-to-back) but never while a step is in flight.
    assign w_accept = bus.start && !r_busy;

    // Next state and command capture.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_op_nxt    = r_op;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_imm_nxt   = r_imm;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (w_accept) begin
                    w_op_nxt  = bus.op;
                    w_src_nxt = bus.src;
                    w_dst_nxt = bus.dst;
                    w_imm_nxt = bus.imm;
                    if (cmd_is_valid(bus.op, bus.src == bus.dst)) begin
                        w_state_nxt = ST_STEP1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STEP1: begin
`ifdef BUS_XFER_CTRL_SWAP_EN
                if (r_op == OP_SWAP) begin
                    w_state_nxt = ST_STEP2;
                end else begin
                    w_state_nxt = ST_FIN;
                end
`else
                w_state_nxt = ST_FIN;
`endif
            end
`ifdef BUS_XFER_CTRL_SWAP_EN
            ST_STEP2: w_state_nxt = ST_STEP3;
            ST_STEP3: w_state_nxt = ST_FIN;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Enables for the state being entered, so they register alongside it.
    always_comb begin
        w_out_en       = 1'b0;
        w_out_idx      = w_src_nxt;
        w_in_en        = 1'b0;
        w_in_idx       = w_dst_nxt;
        w_tmp_out_nxt  = 1'b0;
        w_tmp_in_nxt   = 1'b0;
        w_ext_out_nxt  = 1'b0;
        w_ext_data_nxt = '0;
        case (w_state_nxt)
            ST_STEP1: begin
                case (w_op_nxt)
                    OP_MOVE: begin
                        w_out_en = 1'b1;
                        w_in_en  = 1'b1;
                    end
                    OP_LOAD: begin
                        w_ext_out_nxt  = 1'b1;
                        w_ext_data_nxt = w_imm_nxt;
                        w_in_en        = 1'b1;
                    end
`ifdef BUS_XFER_CTRL_SWAP_EN
                    OP_SWAP: begin
                        w_out_en     = 1'b1;
                        w_tmp_in_nxt = 1'b1;
                    end
`endif
                    default: w_out_en = 1'b0;
                endcase
            end
`ifdef BUS_XFER_CTRL_SWAP_EN
            // Second SWAP step: dst value moves into src.
            ST_STEP2: begin
                w_out_en  = 1'b1;
                w_out_idx = w_dst_nxt;
                w_in_en   = 1'b1;
                w_in_idx  = w_src_nxt;
            end
            // Third SWAP step: saved src value returns from temp into dst.
            ST_STEP3: begin
                w_tmp_out_nxt = 1'b1;
                w_in_en       = 1'b1;
            end
`endif
            default: w_out_en = 1'b0;
        endcase
`ifdef BUS_XFER_CTRL_SWAP_EN
        w_busy_nxt = (w_state_nxt == ST_STEP1) || (w_state_nxt == ST_STEP2) ||
                     (w_state_nxt == ST_STEP3);
`else
        w_busy_nxt = (w_state_nxt == ST_STEP1);
`endif
        w_done_nxt = (w_state_nxt == ST_FIN);
    end

    bus_xfer_dec #(.NREG(NREG), .IW(IW)) u_out_dec (
        .i_idx    (w_out_idx),
        .i_en     (w_out_en),
        .o_onehot (w_reg_out_nxt)
    );

    bus_xfer_dec #(.NREG(NREG), .IW(IW)) u_in_dec (
        .i_idx    (w_in_idx),
        .i_en     (w_in_en),
        .o_onehot (w_reg_in_nxt)
    );

    // State, captured command and registered outputs; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= 2'b00;
            r_src      <= '0;
            r_dst      <= '0;
            r_imm      <= '0;
            r_reg_out  <= '0;
            r_reg_in   <= '0;
            r_tmp_out  <= 1'b0;
            r_tmp_in   <= 1'b0;
            r_ext_out  <= 1'b0;
            r_ext_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_src      <= w_src_nxt;
            r_dst      <= w_dst_nxt;
            r_imm      <= w_imm_nxt;
            r_reg_out  <= w_reg_out_nxt;
            r_reg_in   <= w_reg_in_nxt;
            r_tmp_out  <= w_tmp_out_nxt;
            r_tmp_in   <= w_tmp_in_nxt;
            r_ext_out  <= w_ext_out_nxt;
            r_ext_data <= w_ext_data_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.reg_out  = r_reg_out;
    assign bus.reg_in   = r_reg_in;
    assign bus.tmp_out  = r_tmp_out;
    assign bus.tmp_in   = r_tmp_in;
    assign bus.ext_out  = r_ext_out;
    assign bus.ext_data = r_ext_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

- Control unit that issues register transfers on the shared 4-bit tri-state datapath bus.
- Accepts one transfer command at a time: MOVE, SWAP or LOAD-immediate.
- Sequences the per-register `Rnout`/`Rnin` enables, plus a temp register and an external immediate driver, so that exactly one source drives the bus on each step.
- Sits in `top_level` beside the register file and replaces hand-driven enable stimulus.

## Interface
- `NREG`, 4: number of general registers R0..R(NREG-1); index width `IW = $clog2(NREG)`.
- `DW`, 4: bus/immediate width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe; sampled only while `busy`=0.
- `op` in 2: 00 MOVE, 01 SWAP, 10 LOAD, 11 reserved (error).
- `src` in IW: source register index (MOVE/SWAP).
- `dst` in IW: destination register index.
- `imm` in DW: immediate value for LOAD.
- `reg_out` out NREG: one-hot `Rnout` enables.
- `reg_in` out NREG: one-hot `Rnin` enables.
- `tmp_out`, `tmp_in` out 1: temp register bus enables.
- `ext_out` out 1: external immediate driver enable.
- `ext_data` out DW: immediate presented to the external driver.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse on completion.
- `err` out 1: one-cycle pulse on a rejected command.

## Operation
- FSM states: IDLE, STEP1, STEP2, STEP3, FIN.
- All outputs are registered. Reset value of every output is 0; state returns to IDLE.
- Command capture:
  - `op`/`src`/`dst`/`imm` are latched at the edge where `start`=1 and `busy`=0.
  - Inputs are ignored afterwards until the next accepted command.
- Validation at capture:
  - MOVE/SWAP with `src`==`dst` is rejected.
  - `op`=11 is rejected.
  - A rejected command pulses `err` for one cycle, asserts no enables, and stays IDLE.
- MOVE (1 step), STEP1: `reg_out[src]`, `reg_in[dst]`.
- LOAD (1 step), STEP1: `ext_out`=1, `ext_data`=imm, `reg_in[dst]`.
- SWAP (3 steps):
  - STEP1: `reg_out[src]`, `tmp_in`.
  - STEP2: `reg_out[dst]`, `reg_in[src]`.
  - STEP3: `tmp_out`, `reg_in[dst]`.
- After the last step: FIN for one cycle (`done`=1), then IDLE.
- Invariant: at most one of {`reg_out` bits, `tmp_out`, `ext_out`} is high in any cycle; at most one in-enable is high.
- `ext_data` holds 0 except during a LOAD step.
- `start` while `busy`=1 is dropped; no queuing, no `err`.

## Timing
- Accepting edge E0; step k enables are high for exactly the cycle between edges E(k-1) and Ek.
- The datapath latches on edge Ek.
- `busy` is high from E0 through the last step cycle; it is low in the FIN cycle.
- MOVE/LOAD: `done` in cycle 2 after E0. SWAP: `done` in cycle 4.
- A new `start` in the FIN cycle is accepted (back-to-back allowed). Throughput: MOVE one command per 2 cycles.
- `err` is asserted in the cycle after E0 with `busy`=0.
- Reset mid-operation: at the next edge with `rst`=1, all enables, `busy`, `done` and `err` go to 0, and no further steps issue.
- An aborted SWAP leaves the registers partially swapped. This is acceptable and documented.
- `rst` has priority over `start` at the same edge.

## Configuration
- `BUS_XFER_CTRL_SWAP_EN` defined: SWAP and the STEP2/STEP3 states are compiled in, and `tmp_in`/`tmp_out` are functional.
- Macro undefined:
  - `op`=01 is treated as reserved (`err` pulse).
  - STEP2/STEP3 are absent.
  - `tmp_in`/`tmp_out` are tied to 0.

## Structure
- Package `bus_xfer_pkg` holds:
  - the op encoding constants (`OP_MOVE`, `OP_SWAP`, `OP_LOAD`);
  - the state enum;
  - `DW` default.
- Sub-module `bus_xfer_dec`: index → NREG-bit one-hot with enable. Instantiated once for the out-select and once for the in-select.

## Test plan
- Reset then MOVE src=0 dst=1 with R0=4'hA → one cycle of `reg_out`=0001 and `reg_in`=0010; R1=4'hA; `done` in cycle 2.
- LOAD dst=2 imm=4'h5 → `ext_out`=1 and `ext_data`=5 for one cycle with `reg_in`=0100; R2=5; `ext_data` returns to 0.
- SWAP src=0 dst=1 with R0=3, R1=9 → 3 step cycles in the specified order; R0=9, R1=3; `done` in cycle 4. Without the macro: `err` pulse and no enables.
- MOVE src=2 dst=2, and `op`=11 → `err` pulse; all enables stay 0; `busy` stays 0.
- `start` pulsed during SWAP STEP2 → ignored. `start` in the FIN cycle → accepted; its enables appear in the next cycle.
- `rst` asserted in SWAP STEP2 → next cycle all outputs 0 and FSM IDLE; a following MOVE completes normally.
